// File: rtl/sprite_plotter.sv
// ----------------------------------------------------------------------------
// sprite_plotter
//   Walks a SPR_W x SPR_H sprite ROM in row-major order, one address per
//   cycle. Each ROM colour comes back one cycle later. It is offset by the
//   base position that was latched on start, then qualified and written to
//   the VGA adapter write port.
//
//   The pixel is skipped when it is off-screen. In draw mode it is also
//   skipped when its colour is TRANSP. In erase mode every on-screen pixel
//   of the footprint is painted with bg_colour.
//
//   Frame timing does not depend on pixel content: busy for 27 cycles, then
//   a single done pulse.
//
// Ports
//   clk, resetn           clock / synchronous active-low reset
//   start                 draw request, sampled only in IDLE
//   base_x, base_y        sprite top-left, latched on accepted start
//   erase, bg_colour      erase mode and its colour, latched on accepted start
//   rom_addr / rom_data   sprite ROM port (data valid 1 cycle after address)
//   vga_x, vga_y,
//   vga_colour, vga_plot  adapter write port; vga_plot strobes once per pixel
//   busy, done            frame status
// ----------------------------------------------------------------------------
module sprite_plotter #(
    parameter int              SPR_W  = 5,
    parameter int              SPR_H  = 5,
    parameter int              ADDR_W = 5,
    parameter int              SCR_W  = 160,
    parameter int              SCR_H  = 120,
    parameter int              XW     = 8,
    parameter int              YW     = 7,
    parameter int              COLW   = 3,
    parameter logic [COLW-1:0] TRANSP = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [XW-1:0]     base_x,
    input  logic [YW-1:0]     base_y,
    input  logic              erase,
    input  logic [COLW-1:0]   bg_colour,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [COLW-1:0]   rom_data,
    output logic [XW-1:0]     vga_x,
    output logic [YW-1:0]     vga_y,
    output logic [COLW-1:0]   vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              done
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              r_drain;
    logic [XW-1:0]     r_bx;
    logic [YW-1:0]     r_by;
    logic              r_erase;
    logic [COLW-1:0]   r_bg;
    // (col,row) of the address issued last cycle, aligned with rom_data
    logic              r_p1_vld;
    logic [CW-1:0]     r_p1_col;
    logic [RW-1:0]     r_p1_row;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [COLW-1:0]   r_colour;
    logic              r_plot;
    logic              r_busy;
    logic              r_done;

    // One extra bit so that off-screen pixels can't wrap back into view
    logic [XW:0] w_px;
    logic [YW:0] w_py;
    logic        w_vis;
    logic        w_qual;
    logic        w_last_col;
    logic        w_last_row;

    assign w_px       = (XW+1)'(r_bx) + (XW+1)'(r_p1_col);
    assign w_py       = (YW+1)'(r_by) + (YW+1)'(r_p1_row);
    assign w_vis      = (w_px < (XW+1)'(SCR_W)) && (w_py < (YW+1)'(SCR_H));
    assign w_qual     = r_p1_vld && w_vis && (r_erase || (rom_data != TRANSP));
    assign w_last_col = (r_col == CW'(SPR_W - 1));
    assign w_last_row = (r_row == RW'(SPR_H - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_drain  <= 1'b0;
            r_bx     <= '0;
            r_by     <= '0;
            r_erase  <= 1'b0;
            r_bg     <= '0;
            r_p1_vld <= 1'b0;
            r_p1_col <= '0;
            r_p1_row <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // ROM latency stage: follows the address on rom_addr this cycle
            r_p1_vld <= (r_state == S_SCAN);
            r_p1_col <= r_col;
            r_p1_row <= r_row;

            // Output stage: coordinates/colour hold unless a pixel is written
            r_plot <= w_qual;
            if (w_qual) begin
                r_x      <= w_px[XW-1:0];
                r_y      <= w_py[YW-1:0];
                r_colour <= r_erase ? r_bg : rom_data;
            end

            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bx    <= base_x;
                        r_by    <= base_y;
                        r_erase <= erase;
                        r_bg    <= bg_colour;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Row-major scan, so the address is a plain linear count
                    if (w_last_col) begin
                        r_col <= '0;
                        if (w_last_row) begin
                            r_drain <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_row  <= r_row + RW'(1);
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end else begin
                        r_col  <= r_col + CW'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Two cycles: the last address passes the ROM stage, then the output register
                    if (r_drain) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_plot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// ----------------------------------------------------------------------------
// tb_sprite_plotter
//   Table of frame vectors, two hand-written corner sequences (restart while
//   busy, reset mid-draw), and randomized frames. A cycle-level reference
//   model gives the expected port values: pixel k is plotted at cycle k+3,
//   at (base + k%5, base + k/5), if it is on screen and not transparent.
//   Cycle 0 is the cycle in which start is sampled.
// ----------------------------------------------------------------------------
module tb_sprite_plotter;
    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic       erase;
    logic [2:0] bg_colour;
    logic [4:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int hx = 0, hy = 0, hc = 0;   // last plotted values (outputs hold them)

    logic [2:0] rom [0:31];

    sprite_plotter dut (
        .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
        .erase(erase), .bg_colour(bg_colour), .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after address
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_rom(input int pat);
        for (int i = 0; i < 32; i++) begin
            case (pat)
                0:       rom[i] = 3'b100;
                1:       rom[i] = (i % 2 == 0) ? 3'b010 : 3'b000;
                2:       rom[i] = 3'b001;
                default: rom[i] = 3'($urandom_range(0, 7));
            endcase
        end
    endtask

    // Runs one frame and compares every output in cycles 1..30.
    // restart_c/reset_c < 0 disables that event; exp_n < 0 uses the model count.
    task automatic frame(input string tag, input int bx, input int by, input bit er,
                         input int bg, input int restart_c, input int reset_c,
                         input int exp_n);
        int nplots, nexp;
        nplots = 0;
        nexp   = 0;
        @(negedge clk);
        start = 1'b1; base_x = 8'(bx); base_y = 7'(by); erase = er; bg_colour = 3'(bg);
        @(posedge clk); #1;
        // Scramble the inputs after start: the DUT must use its latched copies
        start = 1'b0; base_x = 8'($urandom); base_y = 7'($urandom);
        erase = 1'($urandom); bg_colour = 3'($urandom);
        for (int c = 1; c <= 30; c++) begin
            bit alive, e_plot;
            int k, px, py;
            alive  = (reset_c < 0) || (c <= reset_c);
            e_plot = 1'b0;
            if (alive && c >= 3 && c <= 27) begin
                k  = c - 3;
                px = bx + k % 5;
                py = by + k / 5;
                if (px < 160 && py < 120 && (er || rom[k] != 3'b000)) begin
                    e_plot = 1'b1;
                    hx = px; hy = py; hc = er ? bg : int'(rom[k]);
                    nexp++;
                end
            end
            if (!alive && c == reset_c + 1) begin hx = 0; hy = 0; hc = 0; end
            chk({tag, " busy"},   busy,     int'(alive && c <= 27));
            chk({tag, " done"},   done,     int'(alive && c == 28));
            chk({tag, " plot"},   vga_plot, int'(e_plot));
            chk({tag, " x"},      vga_x,    hx);
            chk({tag, " y"},      vga_y,    hy);
            chk({tag, " colour"}, vga_colour, hc);
            if (alive && c <= 25) chk({tag, " rom_addr"}, rom_addr, c - 1);
            if (vga_plot) nplots++;
            start  = (c == restart_c);
            if (start) begin base_x = 8'd0; base_y = 7'd0; end
            resetn = !(c == reset_c);
            @(posedge clk); #1;
        end
        start  = 1'b0;
        resetn = 1'b1;
        chk({tag, " plot count"}, nplots, (exp_n < 0) ? nexp : exp_n);
    endtask

    typedef struct {
        string name;
        int    bx, by;
        bit    er;
        int    bg, pat, restart_c, reset_c, exp_n;
    } vec_t;

    vec_t tv [8];

    initial begin
        tv[0] = '{"full",       10,  20,  1'b0, 0, 0, -1, -1, 25};
        tv[1] = '{"checker",     0,   0,  1'b0, 0, 1, -1, -1, 13};
        tv[2] = '{"corner",    158, 118,  1'b0, 0, 2, -1, -1,  4};
        tv[3] = '{"erase",      40,  50,  1'b1, 3, 1, -1, -1, 25};
        tv[4] = '{"edge_x",    159,  10,  1'b1, 5, 1, -1, -1,  5};
        tv[5] = '{"offscr",    255, 127,  1'b0, 0, 0, -1, -1,  0};
        tv[6] = '{"restart",    10,  20,  1'b0, 0, 0, 10, -1, 25};
        tv[7] = '{"bot_edge",    0, 116,  1'b0, 0, 0, -1, -1, 20};

        resetn = 1'b0; start = 1'b0; base_x = '0; base_y = '0; erase = 1'b0; bg_colour = '0;
        set_rom(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset plot", vga_plot, 0);
        chk("reset rom_addr", rom_addr, 0);
        chk("reset x", vga_x, 0);
        chk("reset y", vga_y, 0);
        chk("reset colour", vga_colour, 0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_rom(tv[i].pat);
            frame(tv[i].name, tv[i].bx, tv[i].by, tv[i].er, tv[i].bg,
                  tv[i].restart_c, tv[i].reset_c, tv[i].exp_n);
        end

        // Reset at cycle 12: plots for addresses 0..9 only, then silence
        set_rom(0);
        frame("midreset", 10, 20, 1'b0, 0, -1, 12, 10);
        // The next start after the aborted frame must run normally
        frame("after_reset", 30, 40, 1'b0, 0, -1, -1, 25);

        for (int i = 0; i < 20; i++) begin
            set_rom(3);
            frame("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  1'($urandom), int'($urandom_range(0, 7)), -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
